// File: rtl/mux4_pkg.sv
// Shared types and helpers for the 4-to-1 mux select sequencer.
// Source indices match the mux data inputs a..d.
package mux4_pkg;

  localparam int SRC_N = 4;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [SRC_N-1:0] sel_onehot(input logic [1:0] sel);
    sel_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr
// and returns the first requesting source.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner = ptr;
    any    = 1'b0;
    idx    = '0;
    // Walk from lowest to highest priority so the closest requester overwrites the rest.
    for (int k = SRC_N; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_sel_sequencer.sv
// Round-robin select generator for a 4-to-1 mux: grants one source for a burst
// of BURST handshaked beats, then returns to IDLE for one cycle and rotates priority.
module mux4_sel_sequencer
  import mux4_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       s0,
  output logic       s1,
  output logic       valid,
  output logic [3:0] grant,
  output logic       last
);

  localparam int             CW       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0]  BEAT_MAX = CW'(BURST - 1);

  state_t        state, state_n;
  logic [1:0]    sel, sel_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] beat, beat_n;
  logic [1:0]    winner;
  logic          any;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here; it is not in the sensitivity list.
    if (rst) begin
      // NOTE: sequential state always uses non-blocking assignments.
      state <= IDLE;
      sel   <= SRC_A;
      ptr   <= SRC_D;
      beat  <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    beat_n  = beat;
    case (state)
      IDLE: begin
        // sel only moves on a new grant, so the mux select never glitches while idle.
        if (any) begin
          state_n = GRANT;
          sel_n   = winner;
          ptr_n   = winner;
          beat_n  = '0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_n = IDLE;
        end else if (ready) begin
          if (beat == BEAT_MAX) begin
            state_n = IDLE;
            beat_n  = '0;
          end else begin
            beat_n = beat + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign valid = (state == GRANT);
  assign s1    = sel[1];
  assign s0    = sel[0];
  assign grant = valid ? sel_onehot(sel) : 4'b0000;
  assign last  = valid & (beat == BEAT_MAX);

endmodule
